// File: rtl/instr_encoder.sv
// Encodes symbolic instruction requests into MIPS words and streams them through a FIFO into instruction memory.
// Optional build macro ENC_ILLEGAL_TRAP_EN: illegal kinds set a sticky err and produce no word instead of a NOP.
module instr_encoder #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_kind,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  input  logic        in_last,
  output logic        imem_we,
  input  logic        imem_ready,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] word_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (IMEM_WORDS - 1));

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  typedef enum logic [3:0] {
    K_ADD = 4'd0, K_SUB = 4'd1, K_AND = 4'd2, K_OR = 4'd3, K_ADDI = 4'd4,
    K_ORI = 4'd5, K_BEQ = 4'd6, K_J = 4'd7, K_LW = 4'd8, K_SW = 4'd9
  } kind_t;

  state_t        state, state_next;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [32:0]   mem [DEPTH];
  logic [32:0]   head;
  logic [31:0]   addr;
  logic [31:0]   enc_word;
  logic          fifo_full, fifo_empty;
  logic          accept, push, pop, restart;

  always_comb begin
    enc_word = '0;
    case (in_kind)
      K_ADD:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100000};
      K_SUB:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100010};
      K_AND:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100100};
      K_OR:   enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100101};
      K_ADDI: enc_word = {6'b001000, in_rs, in_rt, in_imm};
      K_ORI:  enc_word = {6'b001101, in_rs, in_rt, in_imm};
      K_BEQ:  enc_word = {6'b000100, in_rs, in_rt, in_imm};
      K_J:    enc_word = {6'b000010, in_target};
      K_LW:   enc_word = {6'b100011, in_rs, in_rt, in_imm};
      K_SW:   enc_word = {6'b101011, in_rs, in_rt, in_imm};
      default: enc_word = '0;
    endcase
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head       = mem[rd_ptr[AW-1:0]];

  // in_ready looks only at the current full flag, so a same-cycle pop never frees a slot early.
  assign in_ready   = (state == S_RUN) && !fifo_full;
  assign imem_we    = ((state == S_RUN) || (state == S_DRAIN)) && !fifo_empty;
  assign imem_addr  = imem_we ? addr : '0;
  assign imem_wdata = imem_we ? head[31:0] : '0;
  assign busy       = (state == S_RUN) || (state == S_DRAIN);
  assign done       = (state == S_DONE);

  assign accept  = in_valid && in_ready;
  assign pop     = imem_we && imem_ready;
  assign restart = (state == S_IDLE) && start;

`ifdef ENC_ILLEGAL_TRAP_EN
  logic illegal_kind;
  assign illegal_kind = (in_kind > 4'd9);
  assign push = accept && !illegal_kind;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (restart) begin
      err <= 1'b0;
    end else if (accept && illegal_kind) begin
      err <= 1'b1;
    end
  end
`else
  assign push = accept;
  assign err  = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (accept && in_last) state_next = S_DRAIN;
      // Empty check covers a trapped last request that never entered the FIFO.
      S_DRAIN: if (fifo_empty || (pop && head[32])) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      addr       <= BASE_ADDR;
      word_count <= '0;
    end else begin
      state <= state_next;
      if (restart) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        addr       <= BASE_ADDR;
        word_count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
          addr   <= (addr == LAST_ADDR) ? BASE_ADDR : addr + 32'd4;
          if (word_count != '1) word_count <= word_count + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {in_last, enc_word};
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a default instance and a small wrapping instance share all stimulus.
// Expected {addr, data} pairs are queued on acceptance and popped by a monitor on each completed write.
module tb_instr_encoder;

  logic        clk, rst_n, start, in_valid, in_last, imem_ready;
  logic [3:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  logic        in_ready0, imem_we0, busy0, done0, err0;
  logic [31:0] imem_addr0, imem_wdata0;
  logic [15:0] word_count0;
  logic        in_ready1, imem_we1, busy1, done1, err1;
  logic [31:0] imem_addr1, imem_wdata1;
  logic [15:0] word_count1;

  localparam logic [31:0] BASE1  = 32'h0000_0100;
  localparam int          WORDS1 = 4;

  instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0000_0000), .IMEM_WORDS(256)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready0),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .imem_we(imem_we0), .imem_ready(imem_ready),
    .imem_addr(imem_addr0), .imem_wdata(imem_wdata0), .busy(busy0), .done(done0),
    .err(err0), .word_count(word_count0)
  );

  instr_encoder #(.DEPTH(4), .BASE_ADDR(BASE1), .IMEM_WORDS(WORDS1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready1),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .imem_we(imem_we1), .imem_ready(imem_ready),
    .imem_addr(imem_addr1), .imem_wdata(imem_wdata1), .busy(busy1), .done(done1),
    .err(err1), .word_count(word_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int acc_count = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [31:0] next0, next1;

`ifdef ENC_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] adv(input logic [31:0] a, input logic [31:0] base, input int words);
    return (a == base + 32'(4 * (words - 1))) ? base : a + 32'd4;
  endfunction

  always @(negedge clk) begin
    logic [63:0] e;
    if (imem_we0 && imem_ready) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write0: addr 0x%08h data 0x%08h, none expected", imem_addr0, imem_wdata0);
      end else begin
        e = q0.pop_front();
        check("wr_addr0", imem_addr0, e[63:32]);
        check("wr_data0", imem_wdata0, e[31:0]);
      end
    end
    if (imem_we1 && imem_ready) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write1: addr 0x%08h data 0x%08h, none expected", imem_addr1, imem_wdata1);
      end else begin
        e = q1.pop_front();
        check("wr_addr1", imem_addr1, e[63:32]);
        check("wr_data1", imem_wdata1, e[31:0]);
      end
    end
  end

  // All tasks are entered and left one time unit after a rising edge.
  task automatic start_seq();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    next0 = 32'h0;
    next1 = BASE1;
  endtask

  task automatic send(input logic [3:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                      input logic last, input logic [31:0] exp, input bit writes);
    bit ok = 1'b0;
    in_kind = kind; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_target = tgt;
    in_last = last; in_valid = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (in_ready0) begin ok = 1'b1; break; end
    end
    if (ok) begin
      acc_count++;
      if (writes) begin
        q0.push_back({next0, exp});
        q1.push_back({next1, exp});
        next0 = adv(next0, 32'h0, 256);
        next1 = adv(next1, BASE1, WORDS1);
      end
      @(posedge clk); #1;
    end else begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stayed 0, kind %0d never accepted", kind);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_wc, input logic exp_err);
    bit seen = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (done0) begin seen = 1'b1; break; end
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_done1"}, 32'(done1), 32'd1);
    check({name, "_wc0"}, 32'(word_count0), 32'(exp_wc));
    check({name, "_wc1"}, 32'(word_count1), 32'(exp_wc));
    check({name, "_err"}, 32'(err0), 32'(exp_err));
    check({name, "_pending"}, 32'(q0.size() + q1.size()), 32'd0);
    @(negedge clk);
    check({name, "_done_one_cycle"}, 32'(done0), 32'd0);
    check({name, "_idle"}, 32'(busy0), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string name);
    check({name, "_in_ready"}, 32'(in_ready0), 32'd0);
    check({name, "_we"}, 32'(imem_we0), 32'd0);
    check({name, "_addr"}, imem_addr0, 32'd0);
    check({name, "_wdata"}, imem_wdata0, 32'd0);
    check({name, "_busy"}, 32'(busy0), 32'd0);
    check({name, "_done"}, 32'(done0), 32'd0);
    check({name, "_err"}, 32'(err0), 32'd0);
    check({name, "_wc"}, 32'(word_count0), 32'd0);
    check({name, "_addr1"}, imem_addr1, 32'd0);
  endtask

  initial begin
    logic [31:0] a_hold, d_hold;
    bit have;
    int acc_base;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; imem_ready = 1'b0;
    in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
    next0 = 32'h0; next1 = BASE1;
    #12;
    check_zero("reset");
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single ADD.
    imem_ready = 1'b1;
    start_seq();
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 32'h0022_1820, 1'b1);
    wait_done("add", 1, 1'b0);

    // Stream of I/J types with junk in unused fields; start mid-stream must be ignored.
    start_seq();
    send(4'd4, 5'd0, 5'd1, 5'd31, 16'h0005, 26'h3FF_FFFF, 1'b0, 32'h2001_0005, 1'b1);
    send(4'd8, 5'd1, 5'd2, 5'd7,  16'h0008, 26'h155_5555, 1'b0, 32'h8C22_0008, 1'b1);
    start = 1'b1;
    send(4'd9, 5'd1, 5'd2, 5'd0,  16'h0004, 26'h0,        1'b0, 32'hAC22_0004, 1'b1);
    start = 1'b0;
    send(4'd6, 5'd1, 5'd2, 5'd9,  16'hFFFF, 26'h0,        1'b0, 32'h1022_FFFF, 1'b1);
    send(4'd7, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h000_0010, 1'b1, 32'h0800_0010, 1'b1);
    wait_done("stream", 5, 1'b0);

    // Back-pressure: memory stalled while six requests are offered.
    imem_ready = 1'b0;
    start_seq();
    acc_base = acc_count;
    have = 1'b0;
    a_hold = '0;
    d_hold = '0;
    fork
      begin
        send(4'd1, 5'd4,  5'd5,  5'd6,  16'h0,    26'h0,        1'b0, 32'h0085_3022, 1'b1);
        send(4'd2, 5'd7,  5'd8,  5'd9,  16'h0,    26'h0,        1'b0, 32'h00E8_4824, 1'b1);
        send(4'd3, 5'd1,  5'd1,  5'd1,  16'h0,    26'h0,        1'b0, 32'h0021_0825, 1'b1);
        send(4'd5, 5'd2,  5'd3,  5'd31, 16'h1234, 26'h0,        1'b0, 32'h3443_1234, 1'b1);
        send(4'd4, 5'd31, 5'd31, 5'd0,  16'hFFFF, 26'h0,        1'b0, 32'h23FF_FFFF, 1'b1);
        send(4'd7, 5'd0,  5'd0,  5'd0,  16'h0,    26'h3FF_FFFF, 1'b1, 32'h0BFF_FFFF, 1'b1);
      end
      begin
        repeat (10) begin
          @(negedge clk);
          if (imem_we0) begin
            if (!have) begin
              a_hold = imem_addr0; d_hold = imem_wdata0; have = 1'b1;
            end else begin
              check("stall_addr_hold", imem_addr0, a_hold);
              check("stall_data_hold", imem_wdata0, d_hold);
            end
          end
        end
        check("stall_accepts", 32'(acc_count - acc_base), 32'd4);
        check("stall_in_ready", 32'(in_ready0), 32'd0);
        check("stall_head_addr", a_hold, 32'h0);
        check("stall_head_data", d_hold, 32'h0085_3022);
        @(posedge clk); #1 imem_ready = 1'b1;
      end
    join
    wait_done("stall", 6, 1'b0);

    // Illegal kind as the last request.
    start_seq();
    send(4'd12, 5'd3, 5'd4, 5'd5, 16'hABCD, 26'h0, 1'b1, 32'h0000_0000, !TRAP);
    wait_done("illegal", TRAP ? 0 : 1, TRAP);

    // Asynchronous reset while draining three queued words.
    imem_ready = 1'b0;
    start_seq();
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 32'h0022_1820, 1'b1);
    send(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0, 32'h0085_3022, 1'b1);
    send(4'd2, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0, 1'b1, 32'h00E8_4824, 1'b1);
    check("drain_busy", 32'(busy0), 32'd1);
    check("drain_we", 32'(imem_we0), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    q0.delete();
    q1.delete();
    imem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    start_seq();
    send(4'd3, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b1, 32'h0021_0825, 1'b1);
    wait_done("after_reset", 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
